// File: rtl/mem_bus_pkg.sv
// Shared types and bus widths for the memory bus scheduler.
package mem_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = 4;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A master is requesting when it reads or asserts any byte strobe.
  function automatic logic has_request(input logic rd, input logic [BUS_MASK_W-1:0] mask);
    return rd | (|mask);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_pick #(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last,
  output logic                           valid,
  output logic [$clog2(NUM_MASTERS)-1:0] pick
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      int cand;
      cand = int'(last) + off;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (req[cand]) begin
        valid = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Round-robin arbiter sharing the single memory bus between several masters,
// with a watchdog that completes stalled transactions with a fault.
module mem_bus_scheduler
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_MASTERS-1:0][BUS_ADDR_W-1:0] address_in,
  input  logic [NUM_MASTERS-1:0]                 read_in,
  input  logic [NUM_MASTERS-1:0][BUS_MASK_W-1:0] write_mask_in,
  input  logic [NUM_MASTERS-1:0][BUS_DATA_W-1:0] write_value_in,
  output logic [NUM_MASTERS-1:0]                 ready_out,
  output logic [NUM_MASTERS-1:0]                 fault_out,
  output logic [BUS_DATA_W-1:0]                  read_value_out,
  output logic [BUS_ADDR_W-1:0]                  address_out,
  output logic                                   read_out,
  output logic [BUS_MASK_W-1:0]                  write_mask_out,
  output logic [BUS_DATA_W-1:0]                  write_value_out,
  input  logic [BUS_DATA_W-1:0]                  read_value_in,
  input  logic                                   ready_in,
  input  logic                                   fault_in
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last;
  logic [WD_W-1:0]  wd;

  logic [NUM_MASTERS-1:0] req_vec;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick;
  logic                   grant_req;
  logic                   timeout_hit;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_vec[i] = has_request(read_in[i], write_mask_in[i]);
    end
  end

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_pick (
    .req  (req_vec),
    .last (last),
    .valid(pick_valid),
    .pick (pick)
  );

  assign grant_req   = req_vec[grant];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd == WD_LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= LAST_RST;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            wd    <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!grant_req) begin
            // Master withdrew its request: abandon without touching `last`.
            state <= IDLE;
          end else if (ready_in || timeout_hit) begin
            last  <= grant;
            state <= IDLE;
          end else if (wd != WD_LIMIT) begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready_out       = '0;
    fault_out       = '0;
    read_value_out  = '0;
    address_out     = '0;
    read_out        = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    if (state == BUSY && grant_req) begin
      if (ready_in || !timeout_hit) begin
        address_out     = address_in[grant];
        read_out        = read_in[grant];
        write_mask_out  = write_mask_in[grant];
        write_value_out = write_value_in[grant];
      end
      // A late ready_in still beats the watchdog in the same cycle.
      if (ready_in) begin
        ready_out[grant] = 1'b1;
        fault_out[grant] = fault_in;
        read_value_out   = read_value_in;
      end else if (timeout_hit) begin
        ready_out[grant] = 1'b1;
        fault_out[grant] = 1'b1;
      end
    end
  end

endmodule
